// File: rtl/vx_om_tile_mem_pkg.sv
// Shared types for the OM tile-buffer memory responder.
package vx_om_tile_mem_pkg;
  localparam int OM_ADDR_W = 16;
  localparam int OM_TAG_W  = 8;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR, S_DONE} om_tile_state_e;

  typedef struct packed {
    logic                 rw;
    logic [OM_ADDR_W-1:0] addr;
    logic [3:0]           byteen;
    logic [31:0]          data;
    logic [OM_TAG_W-1:0]  tag;
  } om_tile_req_t;
endpackage

// File: rtl/vx_om_tile_mem_bank.sv
// One word-wide SRAM bank: byte-masked write, registered read, and a full-word
// clear port that takes over the write port while a tile clear runs.
module vx_om_tile_mem_bank
  import vx_om_tile_mem_pkg::*;
#(
  parameter int ROWS  = 256,
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [3:0]       i_byteen,
  input  logic [ROW_W-1:0] i_row,
  input  logic [31:0]      i_wdata,
  input  logic             i_re,
  input  logic             i_clr_en,
  input  logic [ROW_W-1:0] i_clr_row,
  input  logic [31:0]      i_clr_data,
  output logic [31:0]      o_rdata
);
  logic [31:0]      r_mem [ROWS];
  logic [31:0]      r_rdata;
  logic             w_we;
  logic [ROW_W-1:0] w_row;
  logic [31:0]      w_data;
  logic [3:0]       w_be;

  assign w_we   = i_we | i_clr_en;
  assign w_row  = i_clr_en ? i_clr_row : i_row;
  assign w_data = i_clr_en ? i_clr_data : i_wdata;
  assign w_be   = i_clr_en ? 4'hF : i_byteen;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_row][b*8 +: 8] <= w_data[b*8 +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_row];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/vx_om_tile_mem.sv
// OM cache-bus responder backed by a word-interleaved on-chip tile buffer,
// with per-bank round-robin arbitration, per-port in-order read responses and a tile clear FSM.
module vx_om_tile_mem
  import vx_om_tile_mem_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int TILE_WORDS     = 1024,
  parameter int ADDR_WIDTH     = OM_ADDR_W,
  parameter int TAG_WIDTH      = OM_TAG_W,
  parameter int RSP_QUEUE_SIZE = 4
) (
  input  logic                                 clk,
  input  logic                                 i_reset,
  input  logic [NUM_PORTS-1:0]                 i_req_valid,
  input  logic [NUM_PORTS-1:0]                 i_req_rw,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_PORTS-1:0][3:0]            i_req_byteen,
  input  logic [NUM_PORTS-1:0][31:0]           i_req_data,
  input  logic [NUM_PORTS-1:0][TAG_WIDTH-1:0]  i_req_tag,
  output logic [NUM_PORTS-1:0]                 o_req_ready,
  output logic [NUM_PORTS-1:0]                 o_rsp_valid,
  output logic [NUM_PORTS-1:0][31:0]           o_rsp_data,
  output logic [NUM_PORTS-1:0][TAG_WIDTH-1:0]  o_rsp_tag,
  input  logic [NUM_PORTS-1:0]                 i_rsp_ready,
  input  logic                                 i_clear_valid,
  input  logic [31:0]                          i_clear_value,
  output logic                                 o_clear_ready,
  output logic                                 o_clear_done,
  output logic                                 o_addr_err
);
  localparam int LOG   = $clog2(NUM_PORTS);
  localparam int ROWS  = TILE_WORDS / NUM_PORTS;
  localparam int ROW_W = $clog2(ROWS);
  localparam int CNT_W = $clog2(RSP_QUEUE_SIZE + 1);
  localparam int PTR_W = $clog2(RSP_QUEUE_SIZE);

  om_tile_state_e       r_state;
  logic [ROW_W-1:0]     r_clr_row;
  logic [31:0]          r_clr_value;
  logic                 r_clear_done;
  logic                 r_addr_err;
  logic [LOG-1:0]       r_rr_ptr [NUM_PORTS];
  logic                 w_idle;
  logic                 w_clr_en;
  logic [LOG-1:0]       w_idx;
  logic [NUM_PORTS-1:0] w_bank_any;
  logic [LOG-1:0]       w_gnt [NUM_PORTS];
  logic [LOG-1:0]       w_pbank [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_oor, w_credit, w_acc, w_inflight;
  logic [31:0]          w_rdata [NUM_PORTS];

  assign w_idle        = (r_state == S_IDLE) && !i_reset;
  assign w_clr_en      = (r_state == S_CLEAR);
  assign o_clear_ready = w_idle;
  assign o_clear_done  = r_clear_done;
  assign o_addr_err    = r_addr_err;

  // Scan from the pointer downwards so the requester closest after the pointer wins.
  always_comb begin
    w_idx = '0;
    for (int b = 0; b < NUM_PORTS; b++) begin
      w_bank_any[b] = 1'b0;
      w_gnt[b]      = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        w_idx = r_rr_ptr[b] + LOG'(k);
        if (i_req_valid[w_idx] && (w_pbank[w_idx] == LOG'(b))) begin
          w_bank_any[b] = 1'b1;
          w_gnt[b]      = w_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_PORTS; b++) begin
      if (i_reset) r_rr_ptr[b] <= '0;
      else if (w_bank_any[b] && w_acc[w_gnt[b]]) r_rr_ptr[b] <= w_gnt[b] + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_bank
    logic [LOG-1:0] w_g;
    logic           w_bacc;
    assign w_g    = w_gnt[gi];
    assign w_bacc = w_bank_any[gi] && w_acc[w_g];

    vx_om_tile_mem_bank #(.ROWS(ROWS), .ROW_W(ROW_W)) u_bank (
      .clk        (clk),
      .i_we       (w_bacc && i_req_rw[w_g] && !w_oor[w_g]),
      .i_byteen   (i_req_byteen[w_g]),
      .i_row      (i_req_addr[w_g][LOG +: ROW_W]),
      .i_wdata    (i_req_data[w_g]),
      .i_re       (w_bacc && !i_req_rw[w_g]),
      .i_clr_en   (w_clr_en),
      .i_clr_row  (r_clr_row),
      .i_clr_data (r_clr_value),
      .o_rdata    (w_rdata[gi])
    );
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic                 r_inf_valid, r_inf_oor;
    logic [LOG-1:0]       r_inf_bank;
    logic [TAG_WIDTH-1:0] r_inf_tag;
    logic [31:0]          r_q_data [RSP_QUEUE_SIZE];
    logic [TAG_WIDTH-1:0] r_q_tag  [RSP_QUEUE_SIZE];
    logic [PTR_W-1:0]     r_wptr, r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic                 w_empty, w_push, w_pop, w_win;
    logic [31:0]          w_inf_data;

    assign w_pbank[gi]  = i_req_addr[gi][LOG-1:0];
    assign w_oor[gi]    = 32'(i_req_addr[gi]) >= TILE_WORDS;
    assign w_win        = i_req_valid[gi] && w_bank_any[w_pbank[gi]] && (w_gnt[w_pbank[gi]] == LOG'(gi));
    assign o_req_ready[gi] = w_idle && w_win && (i_req_rw[gi] || w_credit[gi]);
    assign w_acc[gi]    = i_req_valid[gi] && o_req_ready[gi];

    // The read in flight bypasses the queue when it is empty, giving one-cycle latency.
    assign w_empty      = (r_count == '0);
    assign w_inf_data   = r_inf_oor ? 32'h0 : w_rdata[r_inf_bank];
    assign w_push       = r_inf_valid && !(w_empty && i_rsp_ready[gi]);
    assign w_pop        = !w_empty && i_rsp_ready[gi];
    assign w_inflight[gi] = r_inf_valid;
    assign w_credit[gi] = (32'(r_count) + 32'(r_inf_valid)) < RSP_QUEUE_SIZE;
    assign o_rsp_valid[gi] = !w_empty || r_inf_valid;
    assign o_rsp_data[gi]  = w_empty ? w_inf_data : r_q_data[r_rptr];
    assign o_rsp_tag[gi]   = w_empty ? r_inf_tag : r_q_tag[r_rptr];

    always_ff @(posedge clk) begin
      if (i_reset) begin
        r_inf_valid <= 1'b0;
        r_wptr      <= '0;
        r_rptr      <= '0;
        r_count     <= '0;
      end else begin
        r_inf_valid <= w_acc[gi] && !i_req_rw[gi];
        if (w_push) r_wptr <= (32'(r_wptr) == RSP_QUEUE_SIZE - 1) ? '0 : r_wptr + 1'b1;
        if (w_pop)  r_rptr <= (32'(r_rptr) == RSP_QUEUE_SIZE - 1) ? '0 : r_rptr + 1'b1;
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
      r_inf_oor  <= w_oor[gi];
      r_inf_bank <= w_pbank[gi];
      r_inf_tag  <= i_req_tag[gi];
      if (w_push) begin
        r_q_data[r_wptr] <= w_inf_data;
        r_q_tag[r_wptr]  <= r_inf_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_clr_row    <= '0;
      r_clear_done <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      r_clear_done <= 1'b0;
      if (|(w_acc & w_oor)) r_addr_err <= 1'b1;
      case (r_state)
        S_IDLE: if (i_clear_valid) begin
          r_state     <= S_DRAIN;
          r_clr_value <= i_clear_value;
        end
        S_DRAIN: if (!(|w_inflight)) begin
          r_state   <= S_CLEAR;
          r_clr_row <= '0;
        end
        S_CLEAR: begin
          r_clr_row <= r_clr_row + 1'b1;
          if (32'(r_clr_row) == ROWS - 1) begin
            r_state      <= S_DONE;
            r_clear_done <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
